// File: rtl/ycbcr_multi_classifier.sv
// RGB to YCbCr pipeline (3 stages) with per-colour Cb/Cr window classifiers.
// Thresholds are double-buffered and swap in on the rising edge of vsync_i.
module ycbcr_multi_classifier #(
   parameter int unsigned NUM_COLORS = 4,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned LBL_W      = 3
) (
   input  logic                   sclk,
   input  logic                   s_rst_n,
   input  logic [DATA_W-1:0]      rgb_r,
   input  logic [DATA_W-1:0]      rgb_g,
   input  logic [DATA_W-1:0]      rgb_b,
   input  logic                   vsync_i,
   input  logic                   hsync_i,
   input  logic                   cfg_wr,
   input  logic [LBL_W+1:0]       cfg_addr,
   input  logic [DATA_W-1:0]      cfg_wdata,
   input  logic [NUM_COLORS-1:0]  cfg_color_en,
   output logic                   vsync_o,
   output logic                   hsync_o,
   output logic [DATA_W-1:0]      y_o,
   output logic [NUM_COLORS-1:0]  mask_o,
   output logic                   hit_o,
   output logic [LBL_W-1:0]       label_o,
   output logic [7:0]             data_o
);

   localparam int unsigned PW = DATA_W + 8;
   localparam int unsigned SW = DATA_W + 10;
   localparam logic signed [SW-1:0] RND  = SW'(128);
   localparam logic signed [SW-1:0] HALF = SW'(2 ** (DATA_W - 1));
   localparam logic signed [SW-1:0] MAXV = SW'(2 ** DATA_W - 1);

   localparam logic [PW-1:0] K_RY = PW'(77);
   localparam logic [PW-1:0] K_GY = PW'(150);
   localparam logic [PW-1:0] K_BY = PW'(29);
   localparam logic [PW-1:0] K_RB = PW'(43);
   localparam logic [PW-1:0] K_GB = PW'(85);
   localparam logic [PW-1:0] K_128 = PW'(128);
   localparam logic [PW-1:0] K_GR = PW'(107);
   localparam logic [PW-1:0] K_BR = PW'(21);

   function automatic logic [DATA_W-1:0] clamp(input logic signed [SW-1:0] v);
      if (v < 0) return '0;
      else if (v > MAXV) return '1;
      else return v[DATA_W-1:0];
   endfunction

   // Power-on windows: colour0 = blue, colour1 = red, the rest never hit.
   function automatic logic [DATA_W-1:0] dflt(input int unsigned k, input int unsigned f);
      logic [DATA_W-1:0] v;
      v = '0;
      if (k == 0) begin
         case (f)
            0: v = DATA_W'(180);
            1: v = DATA_W'(255);
            2: v = DATA_W'(80);
            3: v = DATA_W'(128);
            default: v = '0;
         endcase
      end else if (k == 1) begin
         case (f)
            0: v = DATA_W'(48);
            1: v = DATA_W'(128);
            2: v = DATA_W'(200);
            3: v = DATA_W'(255);
            default: v = '0;
         endcase
      end
      return v;
   endfunction

   logic [PW-1:0]             r_x, g_x, b_x;
   logic [PW-1:0]             p_d [9];
   logic [PW-1:0]             p_q [9];
   logic signed [SW-1:0]      s [9];
   logic signed [SW-1:0]      y_sum, cb_sum, cr_sum;
   logic [DATA_W-1:0]         y2_d, cb2_d, cr2_d, y2_q, cb2_q, cr2_q;
   logic [NUM_COLORS-1:0]     mask_d, mask_q;
   logic                      hit_d, hit_q, label_found;
   logic [LBL_W-1:0]          label_d, label_q;
   logic [7:0]                data_d, data_q;
   logic [DATA_W-1:0]         y3_q;
   logic [2:0]                vs_d, vs_q, hs_d, hs_q;
   logic                      vsync_rise;
   logic [LBL_W-1:0]          cfg_idx;
   logic [1:0]                cfg_fld;
   logic [DATA_W-1:0]         thr_sh_d [NUM_COLORS][4];
   logic [DATA_W-1:0]         thr_sh_q [NUM_COLORS][4];
   logic [DATA_W-1:0]         thr_act_d [NUM_COLORS][4];
   logic [DATA_W-1:0]         thr_act_q [NUM_COLORS][4];
   logic [NUM_COLORS-1:0]     en_sh_d, en_sh_q, en_act_d, en_act_q;

   // Stage 1: products
   always_comb begin
      r_x = PW'(rgb_r);
      g_x = PW'(rgb_g);
      b_x = PW'(rgb_b);
      p_d[0] = r_x * K_RY;
      p_d[1] = g_x * K_GY;
      p_d[2] = b_x * K_BY;
      p_d[3] = r_x * K_RB;
      p_d[4] = g_x * K_GB;
      p_d[5] = b_x * K_128;
      p_d[6] = r_x * K_128;
      p_d[7] = g_x * K_GR;
      p_d[8] = b_x * K_BR;
   end

   // Stage 2: rounded sums, arithmetic shift, offset and clamp
   always_comb begin
      for (int i = 0; i < 9; i++) s[i] = signed'(SW'(p_q[i]));
      y_sum  = s[0] + s[1] + s[2] + RND;
      cb_sum = s[5] - s[3] - s[4] + RND;
      cr_sum = s[6] - s[7] - s[8] + RND;
      y2_d   = clamp(y_sum >>> 8);
      cb2_d  = clamp((cb_sum >>> 8) + HALF);
      cr2_d  = clamp((cr_sum >>> 8) + HALF);
   end

   // Stage 3: strict window compare against the active set
   always_comb begin
      mask_d      = '0;
      label_d     = '0;
      label_found = 1'b0;
      for (int unsigned k = 0; k < NUM_COLORS; k++) begin
         mask_d[k] = en_act_q[k] & (thr_act_q[k][0] < cb2_q) & (cb2_q < thr_act_q[k][1])
                   & (thr_act_q[k][2] < cr2_q) & (cr2_q < thr_act_q[k][3]);
         if (mask_d[k] && !label_found) begin
            label_d     = LBL_W'(k);
            label_found = 1'b1;
         end
      end
      hit_d  = |mask_d;
      data_d = hit_d ? 8'hFF : 8'h00;
   end

   always_comb begin
      vs_d       = {vs_q[1:0], vsync_i};
      hs_d       = {hs_q[1:0], hsync_i};
      vsync_rise = vsync_i & ~vs_q[0];
      cfg_idx    = cfg_addr[LBL_W+1:2];
      cfg_fld    = cfg_addr[1:0];
      thr_sh_d   = thr_sh_q;
      thr_act_d  = thr_act_q;
      en_sh_d    = cfg_color_en;
      en_act_d   = en_act_q;
      // Active set takes the pre-write shadow when a write coincides with the edge.
      if (vsync_rise) begin
         thr_act_d = thr_sh_q;
         en_act_d  = en_sh_q;
      end
      for (int unsigned k = 0; k < NUM_COLORS; k++) begin
         if (cfg_wr && cfg_idx == LBL_W'(k)) thr_sh_d[k][cfg_fld] = cfg_wdata;
      end
   end

   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         for (int i = 0; i < 9; i++) p_q[i] <= '0;
         y2_q     <= '0;
         cb2_q    <= '0;
         cr2_q    <= '0;
         y3_q     <= '0;
         mask_q   <= '0;
         hit_q    <= 1'b0;
         label_q  <= '0;
         data_q   <= '0;
         vs_q     <= '0;
         hs_q     <= '0;
         en_sh_q  <= '1;
         en_act_q <= '1;
         for (int unsigned k = 0; k < NUM_COLORS; k++) begin
            for (int unsigned f = 0; f < 4; f++) begin
               thr_sh_q[k][f]  <= dflt(k, f);
               thr_act_q[k][f] <= dflt(k, f);
            end
         end
      end else begin
         p_q       <= p_d;
         y2_q      <= y2_d;
         cb2_q     <= cb2_d;
         cr2_q     <= cr2_d;
         y3_q      <= y2_q;
         mask_q    <= mask_d;
         hit_q     <= hit_d;
         label_q   <= label_d;
         data_q    <= data_d;
         vs_q      <= vs_d;
         hs_q      <= hs_d;
         en_sh_q   <= en_sh_d;
         en_act_q  <= en_act_d;
         thr_sh_q  <= thr_sh_d;
         thr_act_q <= thr_act_d;
      end
   end

   assign vsync_o = vs_q[2];
   assign hsync_o = hs_q[2];
   assign y_o     = y3_q;
   assign mask_o  = mask_q;
   assign hit_o   = hit_q;
   assign label_o = label_q;
   assign data_o  = data_q;

endmodule

// File: tb/tb_ycbcr_multi_classifier.sv
// Directed bench for ycbcr_multi_classifier: conversion, windows, shadowing, reset.
module tb_ycbcr_multi_classifier;

   logic       sclk = 1'b0;
   logic       s_rst_n;
   logic [7:0] rgb_r, rgb_g, rgb_b;
   logic       vsync_i, hsync_i, cfg_wr;
   logic [4:0] cfg_addr;
   logic [7:0] cfg_wdata;
   logic [3:0] cfg_color_en;
   logic       vsync_o, hsync_o, hit_o;
   logic [7:0] y_o, data_o;
   logic [3:0] mask_o;
   logic [2:0] label_o;

   int checks = 0;
   int errors = 0;

   ycbcr_multi_classifier #(
      .NUM_COLORS (4),
      .DATA_W     (8),
      .LBL_W      (3)
   ) dut (
      .sclk         (sclk),
      .s_rst_n      (s_rst_n),
      .rgb_r        (rgb_r),
      .rgb_g        (rgb_g),
      .rgb_b        (rgb_b),
      .vsync_i      (vsync_i),
      .hsync_i      (hsync_i),
      .cfg_wr       (cfg_wr),
      .cfg_addr     (cfg_addr),
      .cfg_wdata    (cfg_wdata),
      .cfg_color_en (cfg_color_en),
      .vsync_o      (vsync_o),
      .hsync_o      (hsync_o),
      .y_o          (y_o),
      .mask_o       (mask_o),
      .hit_o        (hit_o),
      .label_o      (label_o),
      .data_o       (data_o)
   );

   always #5 sclk = ~sclk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
      end
   endtask

   task automatic chk_px(input string tag, input logic [7:0] ey, input logic [3:0] em,
                         input logic [2:0] el, input logic eh, input logic [7:0] ed);
      checks++;
      assert (y_o === ey) else begin
         errors++;
         $error("FAIL %s y_o: observed %0d, expected %0d", tag, y_o, ey);
      end
      checks++;
      assert (mask_o === em) else begin
         errors++;
         $error("FAIL %s mask_o: observed %b, expected %b", tag, mask_o, em);
      end
      checks++;
      assert (label_o === el) else begin
         errors++;
         $error("FAIL %s label_o: observed %0d, expected %0d", tag, label_o, el);
      end
      checks++;
      assert (hit_o === eh) else begin
         errors++;
         $error("FAIL %s hit_o: observed %0b, expected %0b", tag, hit_o, eh);
      end
      checks++;
      assert (data_o === ed) else begin
         errors++;
         $error("FAIL %s data_o: observed %h, expected %h", tag, data_o, ed);
      end
   endtask

   // Hold one pixel and wait until it has crossed all three stages.
   task automatic px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      rgb_r = r;
      rgb_g = g;
      rgb_b = b;
      repeat (3) @(negedge sclk);
   endtask

   task automatic cfg_write(input logic [4:0] a, input logic [7:0] d);
      cfg_wr    = 1'b1;
      cfg_addr  = a;
      cfg_wdata = d;
      @(negedge sclk);
      cfg_wr    = 1'b0;
   endtask

   task automatic vs_pulse();
      vsync_i = 1'b1;
      repeat (2) @(negedge sclk);
      chk1("vsync_o_early", vsync_o, 1'b0);
      @(negedge sclk);
      chk1("vsync_o_delay3", vsync_o, 1'b1);
      vsync_i = 1'b0;
      repeat (4) @(negedge sclk);
   endtask

   initial begin
      s_rst_n      = 1'b1;
      rgb_r        = '0;
      rgb_g        = '0;
      rgb_b        = '0;
      vsync_i      = 1'b0;
      hsync_i      = 1'b0;
      cfg_wr       = 1'b0;
      cfg_addr     = '0;
      cfg_wdata    = '0;
      cfg_color_en = 4'hF;
      #3 s_rst_n = 1'b0;
      #1;
      chk_px("reset", 8'd0, 4'b0000, 3'd0, 1'b0, 8'h00);
      chk1("reset_vsync_o", vsync_o, 1'b0);
      chk1("reset_hsync_o", hsync_o, 1'b0);
      repeat (2) @(negedge sclk);
      s_rst_n = 1'b1;

      // Back-to-back stream: blue, red, white, saturated blue
      rgb_r = 8'd0; rgb_g = 8'd0; rgb_b = 8'd200; hsync_i = 1'b1;
      @(negedge sclk);
      rgb_r = 8'd200; rgb_g = 8'd0; rgb_b = 8'd0; hsync_i = 1'b0;
      @(negedge sclk);
      chk_px("latency_early", 8'd0, 4'b0000, 3'd0, 1'b0, 8'h00);
      chk1("hsync_early", hsync_o, 1'b0);
      rgb_r = 8'd255; rgb_g = 8'd255; rgb_b = 8'd255;
      @(negedge sclk);
      chk_px("blue", 8'd23, 4'b0001, 3'd0, 1'b1, 8'hFF);
      chk1("hsync_delay3", hsync_o, 1'b1);
      rgb_r = 8'd0; rgb_g = 8'd0; rgb_b = 8'd255;
      @(negedge sclk);
      chk_px("red", 8'd60, 4'b0010, 3'd1, 1'b1, 8'hFF);
      chk1("hsync_fall", hsync_o, 1'b0);
      @(negedge sclk);
      chk_px("white", 8'd255, 4'b0000, 3'd0, 1'b0, 8'h00);
      @(negedge sclk);
      chk_px("cb_clamp", 8'd29, 4'b0000, 3'd0, 1'b0, 8'h00);

      // Colour2 = blue window; colour index 4 is out of range and must be dropped
      cfg_write(5'd8, 8'd180);
      cfg_write(5'd9, 8'd255);
      cfg_write(5'd10, 8'd80);
      cfg_write(5'd11, 8'd128);
      cfg_write(5'd16, 8'd250);
      px(8'd0, 8'd0, 8'd200);
      chk_px("shadow_only", 8'd23, 4'b0001, 3'd0, 1'b1, 8'hFF);
      vs_pulse();
      px(8'd0, 8'd0, 8'd200);
      chk_px("colour2_live", 8'd23, 4'b0101, 3'd0, 1'b1, 8'hFF);

      cfg_color_en = 4'b1110;
      @(negedge sclk);
      vs_pulse();
      px(8'd0, 8'd0, 8'd200);
      chk_px("en0_cleared", 8'd23, 4'b0100, 3'd2, 1'b1, 8'hFF);
      cfg_color_en = 4'hF;
      @(negedge sclk);
      vs_pulse();
      px(8'd0, 8'd0, 8'd200);
      chk_px("en0_restored", 8'd23, 4'b0101, 3'd0, 1'b1, 8'hFF);

      // Mid-frame cb_lo change only lands at the next frame
      cfg_write(5'd0, 8'd230);
      px(8'd0, 8'd0, 8'd200);
      chk_px("midframe_hold", 8'd23, 4'b0101, 3'd0, 1'b1, 8'hFF);
      vs_pulse();
      px(8'd0, 8'd0, 8'd200);
      chk_px("cb_lo_230", 8'd23, 4'b0100, 3'd2, 1'b1, 8'hFF);

      // Write on the same edge as vsync rise: one extra frame of delay
      vsync_i   = 1'b1;
      cfg_wr    = 1'b1;
      cfg_addr  = 5'd0;
      cfg_wdata = 8'd180;
      @(negedge sclk);
      cfg_wr = 1'b0;
      repeat (2) @(negedge sclk);
      vsync_i = 1'b0;
      repeat (4) @(negedge sclk);
      px(8'd0, 8'd0, 8'd200);
      chk_px("same_edge_delayed", 8'd23, 4'b0100, 3'd2, 1'b1, 8'hFF);
      vs_pulse();
      px(8'd0, 8'd0, 8'd200);
      chk_px("same_edge_applied", 8'd23, 4'b0101, 3'd0, 1'b1, 8'hFF);

      // Asynchronous reset while hits are streaming
      hsync_i = 1'b1;
      px(8'd0, 8'd0, 8'd200);
      @(negedge sclk);
      chk1("hsync_pre_reset", hsync_o, 1'b1);
      #2 s_rst_n = 1'b0;
      #1;
      chk_px("async_reset", 8'd0, 4'b0000, 3'd0, 1'b0, 8'h00);
      chk1("async_reset_hsync", hsync_o, 1'b0);
      @(negedge sclk);
      s_rst_n = 1'b1;
      @(negedge sclk);
      rgb_r = 8'd200; rgb_g = 8'd0; rgb_b = 8'd0;
      @(negedge sclk);
      chk_px("post_reset_early", 8'd0, 4'b0000, 3'd0, 1'b0, 8'h00);
      @(negedge sclk);
      chk_px("post_reset_blue", 8'd23, 4'b0001, 3'd0, 1'b1, 8'hFF);
      chk1("post_reset_hsync", hsync_o, 1'b1);
      @(negedge sclk);
      chk_px("post_reset_red", 8'd60, 4'b0010, 3'd1, 1'b1, 8'hFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
